// File: rtl/main_addsub.sv
// Modular add/subtract unit: registers (X +/- Y) mod MODULUS one cycle after
// in_valid, with an error flag for out-of-range operands.
module main_addsub #(
  parameter int MODULUS = 11,
  parameter int WIDTH   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  input  logic y3,
  input  logic y2,
  input  logic y1,
  input  logic y0,
  input  logic in_valid,
  output logic z3,
  output logic z2,
  output logic z1,
  output logic z0,
  output logic out_valid,
  output logic err
);

  // WIDTH+1 bits so MODULUS=16 and the raw sum both fit without overflow.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= MOD_W) sum = sum - MOD_W;
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    // Wraparound of the WIDTH+1 bit difference cancels once MOD_W is added back.
    diff = {1'b0, a} - {1'b0, b};
    if (a < b) diff = diff + MOD_W;
    return diff[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] w_x_p0;
  logic [WIDTH-1:0] w_y_p0;
  logic             w_oor_p0;
  logic [WIDTH-1:0] w_res_p0;

  logic [WIDTH-1:0] r_z_p1;
  logic             r_vld_p1;
  logic             r_err_p1;

  // ---- stage p0: operand assembly, range check, arithmetic ----
  assign w_x_p0   = {x3, x2, x1, x0};
  assign w_y_p0   = {y3, y2, y1, y0};
  assign w_oor_p0 = ({1'b0, w_x_p0} >= MOD_W) || ({1'b0, w_y_p0} >= MOD_W);
  assign w_res_p0 = w_oor_p0 ? '0 : (s ? mod_sub(w_x_p0, w_y_p0)
                                       : mod_add(w_x_p0, w_y_p0));

  // ---- stage p1: result register; Z holds when no new operands arrive ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z_p1   <= '0;
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      r_err_p1 <= in_valid & w_oor_p0;
      if (in_valid) r_z_p1 <= w_res_p0;
    end
  end

  assign {z3, z2, z1, z0} = r_z_p1;
  assign out_valid        = r_vld_p1;
  assign err              = r_err_p1;

endmodule

// File: tb/tb_main_addsub.sv
// Directed and exhaustive checks of main_addsub in its default configuration
// (MODULUS=11, WIDTH=4).
module tb_main_addsub;

  localparam int MOD = 11;

  logic clk = 1'b0;
  logic rst, s, in_valid;
  logic x3, x2, x1, x0, y3, y2, y1, y0;
  logic z3, z2, z1, z0, out_valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  main_addsub dut (
    .clk(clk), .rst(rst), .s(s),
    .x3(x3), .x2(x2), .x1(x1), .x0(x0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0),
    .in_valid(in_valid),
    .z3(z3), .z2(z2), .z1(z1), .z0(z0),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int z_val();
    return int'({z3, z2, z1, z0});
  endfunction

  // Present one set of inputs, let one edge pass, land 1 time unit after it.
  task automatic step(input logic sv, input logic [3:0] xv, input logic [3:0] yv,
                      input logic vld, input logic rv);
    s        = sv;
    {x3, x2, x1, x0} = xv;
    {y3, y2, y1, y0} = yv;
    in_valid = vld;
    rst      = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int ez, input int ev, input int ee);
    check({tag, ".z"},   z_val(),        ez);
    check({tag, ".vld"}, int'(out_valid), ev);
    check({tag, ".err"}, int'(err),       ee);
  endtask

  initial begin
    int ez;
    s = 0; in_valid = 0; rst = 1;
    {x3, x2, x1, x0} = 4'd0;
    {y3, y2, y1, y0} = 4'd0;

    // Reset for two edges
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    expect_out("reset", 0, 0, 0);

    // Directed add / subtract
    step(0, 7, 8, 1, 0);   expect_out("add7_8", 4, 1, 0);
    step(0, 10, 10, 1, 0); expect_out("add10_10", 9, 1, 0);
    step(1, 3, 5, 1, 0);   expect_out("sub3_5", 9, 1, 0);
    step(1, 10, 0, 1, 0);  expect_out("sub10_0", 10, 1, 0);
    step(1, 4, 4, 1, 0);   expect_out("sub4_4", 0, 1, 0);
    step(0, 5, 6, 1, 0);   expect_out("add5_6", 0, 1, 0);
    step(0, 2, 6, 1, 0);   expect_out("add2_6", 8, 1, 0);

    // Idle cycle: Z holds, flags low
    step(0, 1, 1, 0, 0);   expect_out("idle_hold", 8, 0, 0);

    // Out-of-range operands
    step(0, 12, 1, 1, 0);  expect_out("oor_x12", 0, 1, 1);
    step(0, 1, 2, 1, 0);   expect_out("err_clear", 3, 1, 0);
    step(1, 11, 0, 1, 0);  expect_out("oor_x11", 0, 1, 1);
    step(0, 0, 15, 1, 0);  expect_out("oor_y15", 0, 1, 1);
    step(1, 3, 2, 1, 0);   expect_out("after_oor", 1, 1, 0);

    // Reset wins over in_valid on the same edge
    step(0, 5, 5, 1, 0);   expect_out("pre_rst", 10, 1, 0);
    step(0, 2, 3, 1, 1);   expect_out("rst_prio", 0, 0, 0);
    step(0, 2, 3, 1, 0);   expect_out("post_rst", 5, 1, 0);

    // Exhaustive legal sweep, back-to-back
    for (int sv = 0; sv < 2; sv++)
      for (int xv = 0; xv < MOD; xv++)
        for (int yv = 0; yv < MOD; yv++) begin
          step(sv[0], xv[3:0], yv[3:0], 1, 0);
          ez = (sv == 0) ? (xv + yv) % MOD : (xv - yv + MOD) % MOD;
          expect_out($sformatf("sweep_s%0d_x%0d_y%0d", sv, xv, yv), ez, 1, 0);
        end

    step(0, 0, 0, 0, 0);
    check("final_idle.vld", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
